// File: rtl/imm_encoder.sv
// Encodes a signed immediate into the I/S/B fields of a RISC-V instruction word
// behind a valid/ready handshake. Define IMM_ENCODER_RANGE_CHECK_EN to flag immediates that do not fit.
module imm_encoder #(
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         base_instr,
    input  logic [1:0]          immsrc,
    input  logic [31:0]         imm_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         instr,
    output logic                imm_err,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

    state_t             state, state_nxt;
    logic               capture;
    logic               deliver;
    logic [31:0]        base_p0;
    logic [1:0]         src_p0;
    logic signed [31:0] imm_p0;

    function automatic logic [31:0] encode(input logic [31:0] base, input logic [1:0] src,
                                           input logic signed [31:0] imm);
        logic [31:0] r;
        r = base;
        case (src)
            2'b00: r[31:20] = imm[11:0];
            2'b01: begin
                r[31:25] = imm[11:5];
                r[11:7]  = imm[4:0];
            end
            2'b10: begin
                r[31]    = imm[12];
                r[30:25] = imm[10:5];
                r[11:8]  = imm[4:1];
                r[7]     = imm[11];
            end
            default: r = base;
        endcase
        return r;
    endfunction

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    // Immediate fits when all bits above the field's sign bit replicate it.
    function automatic logic range_err(input logic [1:0] src, input logic signed [31:0] imm);
        logic r;
        case (src)
            2'b00, 2'b01: r = !((&imm[31:11]) || !(|imm[31:11]));
            2'b10:        r = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            default:      r = 1'b1;
        endcase
        return r;
    endfunction
`endif

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                capture  = in_valid;
                if (in_valid) state_nxt = ENC;
            end
            ENC: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                deliver   = out_ready;
                capture   = out_ready && in_valid;
                if (out_ready) state_nxt = in_valid ? ENC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // p0: captured request
    always_ff @(posedge clk) begin
        if (capture) begin
            base_p0 <= base_instr;
            src_p0  <= immsrc;
            imm_p0  <= imm_data;
        end
    end

    // p1: encoded result, held until delivered
    always_ff @(posedge clk) begin
        if (reset) begin
            instr   <= '0;
            imm_err <= 1'b0;
        end else if (state == ENC) begin
            instr   <= encode(base_p0, src_p0, imm_p0);
`ifdef IMM_ENCODER_RANGE_CHECK_EN
            imm_err <= range_err(src_p0, imm_p0);
`else
            imm_err <= (src_p0 == 2'b11);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                   err_count <= '0;
        else if (deliver && imm_err) err_count <= sat_inc(err_count);
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors plus randomized traffic
// against a transaction-level reference model.
module tb_imm_encoder;

    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   base_instr = '0;
    logic [1:0]    immsrc = '0;
    logic [31:0]   imm_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   instr;
    logic          imm_err;
    logic [CW-1:0] err_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model state: one outstanding request, its age in edges, expected result.
    bit            m_pend = 0;
    int            m_age = 0;
    int            m_cnt = 0;
    logic [31:0]   m_instr = '0;
    logic          m_err = 1'b0;
    logic [1:0]    m_src = '0;
    logic [31:0]   m_imm = '0;

    imm_encoder #(.ERRCNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .base_instr(base_instr), .immsrc(immsrc), .imm_data(imm_data),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .imm_err(imm_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_encode(input logic [31:0] b, input logic [1:0] s,
                                               input logic [31:0] d);
        case (s)
            2'd0: return (b & 32'h000F_FFFF) | ((d & 32'hFFF) << 20);
            2'd1: return (b & 32'h01FF_F07F) | (((d >> 5) & 32'h7F) << 25) | ((d & 32'h1F) << 7);
            2'd2: return (b & 32'h01FF_F07F) | (((d >> 12) & 1) << 31) | (((d >> 5) & 32'h3F) << 25)
                       | (((d >> 1) & 32'hF) << 8) | (((d >> 11) & 1) << 7);
            default: return b;
        endcase
    endfunction

    function automatic bit in_range(input logic [1:0] s, input logic [31:0] d);
        int sd;
        sd = $signed(d);
        if (s == 2'd2) return (sd >= -4096) && (sd <= 4095) && (d[0] == 1'b0);
        if (s == 2'd3) return 1'b0;
        return (sd >= -2048) && (sd <= 2047);
    endfunction

    function automatic logic ref_err(input logic [1:0] s, input logic [31:0] d);
`ifdef IMM_ENCODER_RANGE_CHECK_EN
        return (s == 2'd3) || !in_range(s, d);
`else
        return (s == 2'd3) || (d !== d);
`endif
    endfunction

    function automatic logic [31:0] decode(input logic [1:0] s, input logic [31:0] i);
        logic signed [31:0] v;
        case (s)
            2'd0:    v = $signed({{20{i[31]}}, i[31:20]});
            2'd1:    v = $signed({{20{i[31]}}, i[31:25], i[11:7]});
            default: v = $signed({{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0});
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        bit dlv, acc;
        if (reset) begin
            m_pend = 0;
            m_age  = 0;
            m_cnt  = 0;
        end else begin
            dlv = m_pend && (m_age >= 1) && out_ready;
            acc = in_valid && (!m_pend || dlv);
            if (dlv) begin
                if (m_err && m_cnt < CMAX) m_cnt++;
                m_pend = 0;
            end
            if (acc) begin
                m_pend  = 1;
                m_age   = 0;
                m_src   = immsrc;
                m_imm   = imm_data;
                m_instr = ref_encode(base_instr, immsrc, imm_data);
                m_err   = ref_err(immsrc, imm_data);
            end else if (m_pend) begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, (m_pend && m_age >= 1));
            chk("in_ready", in_ready, (!m_pend || (m_age >= 1 && out_ready)));
            chk("err_count", err_count, m_cnt);
            if (m_pend && m_age >= 1 && out_valid) begin
                chk("instr", instr, m_instr);
                chk("imm_err", imm_err, m_err);
                if (in_range(m_src, m_imm)) chk("roundtrip", decode(m_src, instr), m_imm);
            end
        end
    end

    task automatic send(input logic [31:0] b, input logic [1:0] s, input logic [31:0] d);
        int  n = 0;
        bit  got = 0;
        in_valid = 1'b1; base_instr = b; immsrc = s; imm_data = d;
        while (!got && n < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept", got, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [31:0] i, output logic e);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out_wait", out_valid, 1);
        i = instr;
        e = imm_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ri, held;
        logic        re;
        int          sel;
        logic [31:0] edge_vals [8] = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049,
                                       32'd4094, -32'sd4096, 32'd4095, 32'd4096};

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        reset  = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_imm_err", imm_err, 0);
        chk("rst_err_count", err_count, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        send(32'h0000_0013, 2'd0, 32'hFFFF_F800);
        wait_out(ri, re);
        chk("i_vec", ri, 32'h8000_0013);
        chk("i_vec_err", re, 0);

        // 0x7F puts imm[6:5]=11 into instr[26:25]; 0x3F sets only instr[25]
        send(32'h0000_2023, 2'd1, 32'h0000_007F);
        wait_out(ri, re);
        chk("s_vec7f", ri, 32'h0600_2FA3);
        chk("s_vec7f_err", re, 0);
        send(32'h0000_2023, 2'd1, 32'h0000_003F);
        wait_out(ri, re);
        chk("s_vec3f", ri, 32'h0200_2FA3);

        send(32'h0000_0063, 2'd2, 32'hFFFF_FFFE);
        wait_out(ri, re);
        chk("b_vec", ri, 32'hFE00_0FE3);
        chk("b_vec_err", re, 0);

        send(32'h0000_0063, 2'd2, 32'h0000_0003);
        wait_out(ri, re);
        chk("b_odd", ri, 32'h0000_0163);
        @(negedge clk);
`ifdef IMM_ENCODER_RANGE_CHECK_EN
        chk("b_odd_err", re, 1);
        chk("b_odd_cnt", err_count, 1);
`else
        chk("b_odd_err", re, 0);
        chk("b_odd_cnt", err_count, 0);
`endif
        @(posedge clk);
        #1;

        // Stall in DONE, then a same-edge deliver+accept
        out_ready = 1'b0;
        send(32'h0000_0013, 2'd0, 32'h0000_0005);
        @(negedge clk);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        held = instr;
        chk("stall_val", held, 32'h0050_0013);
        repeat (5) begin
            @(negedge clk);
            chk("stall_instr", instr, held);
            chk("stall_valid", out_valid, 1);
            chk("stall_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1; base_instr = 32'h0000_0013; immsrc = 2'd0; imm_data = 32'h0000_07FF;
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_enc", out_valid, 0);
        @(negedge clk);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_instr", instr, 32'h7FF0_0013);
        @(posedge clk);
        #1;

        for (int k = 0; k < CMAX + 2; k++) begin
            send(32'h0000_1073 + k, 2'd3, 32'h0000_0010);
            wait_out(ri, re);
        end
        @(negedge clk);
        chk("sat_cnt", err_count, CMAX);
        @(posedge clk);
        #1;

        // Reset while the request is being encoded
        send(32'h0000_0013, 2'd0, 32'h0000_0001);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("enc_rst_valid", out_valid, 0);
        chk("enc_rst_ready", in_ready, 1);
        chk("enc_rst_cnt", err_count, 0);
        @(posedge clk);
        #1;
        send(32'h1234_5678, 2'd3, 32'h0000_0000);
        wait_out(ri, re);
        chk("illegal_instr", ri, 32'h1234_5678);
        chk("illegal_err", re, 1);
        @(negedge clk);
        chk("illegal_cnt", err_count, 1);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            reset      = ($urandom_range(0, 149) == 0);
            in_valid   = $urandom_range(0, 1);
            out_ready  = ($urandom_range(0, 3) != 0);
            base_instr = $urandom;
            immsrc     = $urandom_range(0, 3);
            sel        = $urandom_range(0, 3);
            case (sel)
                0:       imm_data = $urandom_range(0, 8191) - 4096;
                1:       imm_data = $urandom;
                2:       imm_data = ($urandom_range(0, 8191) - 4096) & ~32'h1;
                default: imm_data = edge_vals[$urandom_range(0, 7)];
            endcase
        end
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
